// File: rtl/video_mode_ctrl.sv
// Mode sequencer for the video timing counter: accepts modes over valid/ready and
// applies each at a frame boundary, holding the counter in reset and blanking across the switch.
module video_mode_ctrl #(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned SETTLE_FRAMES = 2,
    parameter int unsigned MAX_TOTAL_H   = 4095,
    parameter int unsigned MAX_TOTAL_V   = 4095
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        i_cfg_valid,
    output logic        o_cfg_ready,
    input  logic [11:0] i_cfg_pulse_h,
    input  logic [11:0] i_cfg_bporch_h,
    input  logic [11:0] i_cfg_active_h,
    input  logic [11:0] i_cfg_fporch_h,
    input  logic [11:0] i_cfg_pulse_v,
    input  logic [11:0] i_cfg_bporch_v,
    input  logic [11:0] i_cfg_active_v,
    input  logic [11:0] i_cfg_fporch_v,
    output logic        o_cfg_err,
    input  logic [31:0] i_vtc_h_pixel,
    input  logic [31:0] i_vtc_line,
    output logic [11:0] o_pulse_h,
    output logic [11:0] o_bporch_h,
    output logic [11:0] o_fporch_h,
    output logic [11:0] o_pulse_v,
    output logic [11:0] o_bporch_v,
    output logic [11:0] o_fporch_v,
    output logic [12:0] o_total_h,
    output logic [12:0] o_total_v,
    output logic        o_vtc_rst_n,
    output logic        o_blank,
    output logic        o_locked
);

    localparam int unsigned HoldW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned SettleW = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
    localparam logic [HoldW-1:0]   HoldLast   = HoldW'(HOLD_CYCLES - 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_FRAMES - 1);

    typedef enum logic [1:0] {StRun, StPending, StHold, StSettle} state_e;

    state_e              r_state;
    logic [HoldW-1:0]    r_hold_cnt;
    logic [SettleW-1:0]  r_settle_cnt;
    logic                r_cfg_ready;
    logic                r_cfg_err;
    logic                r_vtc_rst_n;
    logic                r_blank;
    logic                r_locked;
    logic [11:0]         r_pulse_h, r_bporch_h, r_fporch_h;
    logic [11:0]         r_pulse_v, r_bporch_v, r_fporch_v;
    logic [12:0]         r_total_h, r_total_v;
    logic [11:0]         r_sh_pulse_h, r_sh_bporch_h, r_sh_fporch_h;
    logic [11:0]         r_sh_pulse_v, r_sh_bporch_v, r_sh_fporch_v;
    logic [12:0]         r_sh_total_h, r_sh_total_v;

    // One extra bit so four maximal fields cannot wrap into a legal-looking total.
    logic [13:0] w_req_total_h;
    logic [13:0] w_req_total_v;
    logic        w_fields_ok;
    logic        w_legal;
    logic        w_xfer;
    logic        w_frame_end;

    assign w_req_total_h = {2'b00, i_cfg_pulse_h} + {2'b00, i_cfg_bporch_h}
                         + {2'b00, i_cfg_active_h} + {2'b00, i_cfg_fporch_h};
    assign w_req_total_v = {2'b00, i_cfg_pulse_v} + {2'b00, i_cfg_bporch_v}
                         + {2'b00, i_cfg_active_v} + {2'b00, i_cfg_fporch_v};
    assign w_fields_ok = (i_cfg_pulse_h != '0) && (i_cfg_bporch_h != '0)
                      && (i_cfg_active_h != '0) && (i_cfg_fporch_h != '0)
                      && (i_cfg_pulse_v != '0) && (i_cfg_bporch_v != '0)
                      && (i_cfg_active_v != '0) && (i_cfg_fporch_v != '0);
    assign w_legal = w_fields_ok && (w_req_total_h <= 14'(MAX_TOTAL_H))
                  && (w_req_total_v <= 14'(MAX_TOTAL_V));
    assign w_xfer = i_cfg_valid && r_cfg_ready;
    assign w_frame_end = (i_vtc_h_pixel == ({19'd0, r_total_h} - 32'd1))
                      && (i_vtc_line == ({19'd0, r_total_v} - 32'd1));

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_state       <= StHold;
            r_hold_cnt    <= '0;
            r_settle_cnt  <= '0;
            r_cfg_ready   <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_vtc_rst_n   <= 1'b0;
            r_blank       <= 1'b1;
            r_locked      <= 1'b0;
            r_pulse_h     <= 12'd96;
            r_bporch_h    <= 12'd48;
            r_fporch_h    <= 12'd16;
            r_pulse_v     <= 12'd2;
            r_bporch_v    <= 12'd33;
            r_fporch_v    <= 12'd10;
            r_total_h     <= 13'd800;
            r_total_v     <= 13'd525;
            r_sh_pulse_h  <= 12'd96;
            r_sh_bporch_h <= 12'd48;
            r_sh_fporch_h <= 12'd16;
            r_sh_pulse_v  <= 12'd2;
            r_sh_bporch_v <= 12'd33;
            r_sh_fporch_v <= 12'd10;
            r_sh_total_h  <= 13'd800;
            r_sh_total_v  <= 13'd525;
        end else begin
            r_cfg_err <= 1'b0;
            unique case (r_state)
                StRun: begin
                    // A frame_end coinciding with the transfer is ignored; apply waits a frame.
                    if (w_xfer) begin
                        if (w_legal) begin
                            r_sh_pulse_h  <= i_cfg_pulse_h;
                            r_sh_bporch_h <= i_cfg_bporch_h;
                            r_sh_fporch_h <= i_cfg_fporch_h;
                            r_sh_pulse_v  <= i_cfg_pulse_v;
                            r_sh_bporch_v <= i_cfg_bporch_v;
                            r_sh_fporch_v <= i_cfg_fporch_v;
                            r_sh_total_h  <= w_req_total_h[12:0];
                            r_sh_total_v  <= w_req_total_v[12:0];
                            r_cfg_ready   <= 1'b0;
                            r_state       <= StPending;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                StPending: begin
                    if (w_frame_end) begin
                        r_pulse_h   <= r_sh_pulse_h;
                        r_bporch_h  <= r_sh_bporch_h;
                        r_fporch_h  <= r_sh_fporch_h;
                        r_pulse_v   <= r_sh_pulse_v;
                        r_bporch_v  <= r_sh_bporch_v;
                        r_fporch_v  <= r_sh_fporch_v;
                        r_total_h   <= r_sh_total_h;
                        r_total_v   <= r_sh_total_v;
                        r_vtc_rst_n <= 1'b0;
                        r_blank     <= 1'b1;
                        r_locked    <= 1'b0;
                        r_hold_cnt  <= '0;
                        r_state     <= StHold;
                    end
                end
                StHold: begin
                    if (r_hold_cnt == HoldLast) begin
                        r_vtc_rst_n  <= 1'b1;
                        r_settle_cnt <= '0;
                        r_state      <= StSettle;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                StSettle: begin
                    if (w_frame_end) begin
                        if (r_settle_cnt == SettleLast) begin
                            r_blank     <= 1'b0;
                            r_locked    <= 1'b1;
                            r_cfg_ready <= 1'b1;
                            r_state     <= StRun;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= StHold;
            endcase
        end
    end

    assign o_cfg_ready = r_cfg_ready;
    assign o_cfg_err   = r_cfg_err;
    assign o_vtc_rst_n = r_vtc_rst_n;
    assign o_blank     = r_blank;
    assign o_locked    = r_locked;
    assign o_pulse_h   = r_pulse_h;
    assign o_bporch_h  = r_bporch_h;
    assign o_fporch_h  = r_fporch_h;
    assign o_pulse_v   = r_pulse_v;
    assign o_bporch_v  = r_bporch_v;
    assign o_fporch_v  = r_fporch_v;
    assign o_total_h   = r_total_h;
    assign o_total_v   = r_total_v;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: mode table with a scoreboard queue, frame_end driven directly
// at the expected totals so full-length frames are not simulated.
module tb_video_mode_ctrl;

    logic        clock_in = 1'b0;
    logic        reset;
    logic        i_cfg_valid;
    logic        o_cfg_ready;
    logic [11:0] i_cfg_pulse_h, i_cfg_bporch_h, i_cfg_active_h, i_cfg_fporch_h;
    logic [11:0] i_cfg_pulse_v, i_cfg_bporch_v, i_cfg_active_v, i_cfg_fporch_v;
    logic        o_cfg_err;
    logic [31:0] i_vtc_h_pixel, i_vtc_line;
    logic [11:0] o_pulse_h, o_bporch_h, o_fporch_h, o_pulse_v, o_bporch_v, o_fporch_v;
    logic [12:0] o_total_h, o_total_v;
    logic        o_vtc_rst_n, o_blank, o_locked;

    video_mode_ctrl #(
        .HOLD_CYCLES  (16),
        .SETTLE_FRAMES(2),
        .MAX_TOTAL_H  (4095),
        .MAX_TOTAL_V  (4095)
    ) dut (
        .clock_in      (clock_in),
        .reset         (reset),
        .i_cfg_valid   (i_cfg_valid),
        .o_cfg_ready   (o_cfg_ready),
        .i_cfg_pulse_h (i_cfg_pulse_h),
        .i_cfg_bporch_h(i_cfg_bporch_h),
        .i_cfg_active_h(i_cfg_active_h),
        .i_cfg_fporch_h(i_cfg_fporch_h),
        .i_cfg_pulse_v (i_cfg_pulse_v),
        .i_cfg_bporch_v(i_cfg_bporch_v),
        .i_cfg_active_v(i_cfg_active_v),
        .i_cfg_fporch_v(i_cfg_fporch_v),
        .o_cfg_err     (o_cfg_err),
        .i_vtc_h_pixel (i_vtc_h_pixel),
        .i_vtc_line    (i_vtc_line),
        .o_pulse_h     (o_pulse_h),
        .o_bporch_h    (o_bporch_h),
        .o_fporch_h    (o_fporch_h),
        .o_pulse_v     (o_pulse_v),
        .o_bporch_v    (o_bporch_v),
        .o_fporch_v    (o_fporch_v),
        .o_total_h     (o_total_h),
        .o_total_v     (o_total_v),
        .o_vtc_rst_n   (o_vtc_rst_n),
        .o_blank       (o_blank),
        .o_locked      (o_locked)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic [11:0] ph, bh, ah, fh, pv, bv, av, fv;
        logic        legal;
        logic        at_fe;
        logic [12:0] th, tv;
    } vec_t;

    vec_t        vecs[9];
    vec_t        sb[$];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [12:0] cur_th, cur_tv;

    function automatic vec_t mk(input int ph, bh, ah, fh, pv, bv, av, fv,
                                input bit legal, at_fe, input int th, tv);
        vec_t v;
        v.ph = 12'(ph); v.bh = 12'(bh); v.ah = 12'(ah); v.fh = 12'(fh);
        v.pv = 12'(pv); v.bv = 12'(bv); v.av = 12'(av); v.fv = 12'(fv);
        v.legal = legal; v.at_fe = at_fe; v.th = 13'(th); v.tv = 13'(tv);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic set_pos(input logic [31:0] h, input logic [31:0] l);
        i_vtc_h_pixel = h;
        i_vtc_line    = l;
    endtask

    task automatic frame_end();
        set_pos(32'(cur_th) - 32'd1, 32'(cur_tv) - 32'd1);
        tick();
        set_pos(32'd0, 32'd0);
    endtask

    task automatic drive_cfg(input vec_t v);
        i_cfg_pulse_h = v.ph; i_cfg_bporch_h = v.bh; i_cfg_active_h = v.ah; i_cfg_fporch_h = v.fh;
        i_cfg_pulse_v = v.pv; i_cfg_bporch_v = v.bv; i_cfg_active_v = v.av; i_cfg_fporch_v = v.fv;
    endtask

    task automatic chk_defaults(input string p);
        chk({p, "_total_h"}, 32'(o_total_h), 800);
        chk({p, "_total_v"}, 32'(o_total_v), 525);
        chk({p, "_pulse_h"}, 32'(o_pulse_h), 96);
        chk({p, "_bporch_h"}, 32'(o_bporch_h), 48);
        chk({p, "_fporch_h"}, 32'(o_fporch_h), 16);
        chk({p, "_pulse_v"}, 32'(o_pulse_v), 2);
        chk({p, "_bporch_v"}, 32'(o_bporch_v), 33);
        chk({p, "_fporch_v"}, 32'(o_fporch_v), 10);
        chk({p, "_vtc_rst_n"}, 32'(o_vtc_rst_n), 0);
        chk({p, "_blank"}, 32'(o_blank), 1);
        chk({p, "_locked"}, 32'(o_locked), 0);
        chk({p, "_cfg_ready"}, 32'(o_cfg_ready), 0);
        chk({p, "_cfg_err"}, 32'(o_cfg_err), 0);
    endtask

    // Entered right after the edge that dropped vtc_rst_n (or reset release).
    task automatic lock_seq(input bit abort);
        int n = 0;
        chk("hold_entry_rst_n", 32'(o_vtc_rst_n), 0);
        while (o_vtc_rst_n === 1'b0 && n < 100) begin
            n++;
            tick();
        end
        chk("hold_len", n, 16);
        chk("settle_blank", 32'(o_blank), 1);
        chk("settle_locked", 32'(o_locked), 0);
        chk("settle_ready", 32'(o_cfg_ready), 0);
        chk("settle_err", 32'(o_cfg_err), 0);
        tick(); tick();
        frame_end();
        chk("frame1_blank", 32'(o_blank), 1);
        chk("frame1_locked", 32'(o_locked), 0);
        if (abort) return;
        tick(); tick();
        frame_end();
        chk("lock_blank", 32'(o_blank), 0);
        chk("lock_locked", 32'(o_locked), 1);
        chk("lock_ready", 32'(o_cfg_ready), 1);
        chk("lock_rst_n", 32'(o_vtc_rst_n), 1);
    endtask

    task automatic offer(input vec_t v);
        drive_cfg(v);
        i_cfg_valid = 1'b1;
        if (v.at_fe) set_pos(32'(cur_th) - 32'd1, 32'(cur_tv) - 32'd1);
        else         set_pos(32'd0, 32'd0);
        sb.push_back(v);
        tick();
        i_cfg_valid = 1'b0;
        set_pos(32'd0, 32'd0);
    endtask

    // Called right after the accepting edge; finishes the switch and relocks.
    task automatic finish_switch(input bit abort);
        vec_t e;
        e = sb.pop_front();
        chk("accept_ready", 32'(o_cfg_ready), 0);
        chk("accept_err", 32'(o_cfg_err), 0);
        chk("pending_locked", 32'(o_locked), 1);
        chk("pending_blank", 32'(o_blank), 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("pending_total_h", 32'(o_total_h), 32'(cur_th));
            chk("pending_rst_n", 32'(o_vtc_rst_n), 1);
        end
        if (e.th != cur_th) begin
            set_pos(32'(e.th) - 32'd1, 32'(e.tv) - 32'd1);
            tick();
            set_pos(32'd0, 32'd0);
            chk("no_early_apply", 32'(o_vtc_rst_n), 1);
        end
        frame_end();
        chk("apply_total_h", 32'(o_total_h), 32'(e.th));
        chk("apply_total_v", 32'(o_total_v), 32'(e.tv));
        chk("apply_pulse_h", 32'(o_pulse_h), 32'(e.ph));
        chk("apply_bporch_h", 32'(o_bporch_h), 32'(e.bh));
        chk("apply_fporch_h", 32'(o_fporch_h), 32'(e.fh));
        chk("apply_pulse_v", 32'(o_pulse_v), 32'(e.pv));
        chk("apply_bporch_v", 32'(o_bporch_v), 32'(e.bv));
        chk("apply_fporch_v", 32'(o_fporch_v), 32'(e.fv));
        chk("apply_blank", 32'(o_blank), 1);
        chk("apply_locked", 32'(o_locked), 0);
        cur_th = e.th;
        cur_tv = e.tv;
        lock_seq(abort);
    endtask

    task automatic reject(input vec_t v);
        vec_t e;
        offer(v);
        e = sb.pop_front();
        chk("rej_err", 32'(o_cfg_err), e.legal ? 0 : 1);
        chk("rej_ready", 32'(o_cfg_ready), 1);
        chk("rej_locked", 32'(o_locked), 1);
        chk("rej_total_h", 32'(o_total_h), 32'(cur_th));
        chk("rej_total_v", 32'(o_total_v), 32'(cur_tv));
        tick();
        chk("rej_err_clear", 32'(o_cfg_err), 0);
        chk("rej_ready_hold", 32'(o_cfg_ready), 1);
        chk("rej_rst_n", 32'(o_vtc_rst_n), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(128, 88, 800, 40, 4, 23, 600, 1, 1, 0, 1056, 628);
        vecs[1] = mk(96, 48, 0, 16, 2, 33, 480, 10, 0, 1, 0, 0);
        vecs[2] = mk(2048, 1024, 1000, 24, 2, 33, 480, 10, 0, 0, 0, 0);
        vecs[3] = mk(1000, 1000, 1000, 1095, 1, 1, 4092, 1, 1, 0, 4095, 4095);
        vecs[4] = mk(96, 48, 640, 16, 1, 1, 4093, 1, 0, 0, 0, 0);
        vecs[5] = mk(96, 48, 640, 16, 2, 33, 480, 0, 0, 0, 0, 0);
        vecs[6] = mk(4095, 4095, 1, 1, 2, 33, 480, 10, 0, 0, 0, 0);
        vecs[7] = mk(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 4, 4);
        vecs[8] = mk(96, 48, 640, 16, 2, 33, 480, 10, 1, 0, 800, 525);

        reset = 1'b0;
        i_cfg_valid = 1'b0;
        drive_cfg(vecs[8]);
        set_pos(32'd0, 32'd0);
        cur_th = 13'd800;
        cur_tv = 13'd525;
        tick(); tick(); tick();
        chk_defaults("reset");
        reset = 1'b1;
        lock_seq(0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].legal) begin
                offer(vecs[i]);
                finish_switch(0);
            end else begin
                reject(vecs[i]);
            end
        end

        // Second mode held valid through the whole first switch.
        offer(vecs[0]);
        drive_cfg(vecs[7]);
        i_cfg_valid = 1'b1;
        sb.push_back(vecs[7]);
        finish_switch(0);
        tick();
        i_cfg_valid = 1'b0;
        finish_switch(0);

        offer(vecs[3]);
        finish_switch(1);
        reset = 1'b0;
        #1;
        chk_defaults("midreset");
        tick();
        reset = 1'b1;
        sb.delete();
        cur_th = 13'd800;
        cur_tv = 13'd525;
        lock_seq(0);
        frame_end();
        chk("run_fe_rst_n", 32'(o_vtc_rst_n), 1);
        chk("run_fe_locked", 32'(o_locked), 1);
        chk("run_fe_total_h", 32'(o_total_h), 800);
        chk("run_fe_total_v", 32'(o_total_v), 525);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
